ram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the MIPS data RAM. It shares the single RAM port between the CPU load/store stage and a loader/debug port that pre-fills or inspects data memory. Each requester gets a req/ready handshake. The block drives the RAM address, write data and enables, registers read data, and rejects misaligned or out-of-range word accesses.

---
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port (CPU / loader) arbiter and access sequencer for the single-port MIPS data RAM.
// Optional build macro RAM_ARB_FIXED_PRIO_EN: CPU always wins ties (default: round-robin).
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshake: a requester raises req with we/addr/wdata stable and holds them
  // until its one-cycle ready pulse; err and rdata are valid only with ready.
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_ready,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  c_err,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_ready,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  l_err,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * 4);

  logic [1:0]            state;
  logic                  lat_we;
  logic                  lat_err;
  logic                  lat_port;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                  last_grant;
`endif

  logic                  grant_ldr;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    grant_ldr = 1'b0;
    if (c_req && l_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      grant_ldr = 1'b0;
`else
      grant_ldr = (last_grant == PORT_CPU);
`endif
    end else begin
      grant_ldr = l_req;
    end
    sel_we    = grant_ldr ? l_we    : c_we;
    sel_addr  = grant_ldr ? l_addr  : c_addr;
    sel_wdata = grant_ldr ? l_wdata : c_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
  end

  // Writes and rejected accesses return zero data.
  assign rd_val = (!lat_we && !lat_err) ? ram_data_out : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_port  <= PORT_CPU;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant <= PORT_LDR;
`endif
      c_ready   <= 1'b0;
      l_ready   <= 1'b0;
      c_err     <= 1'b0;
      l_err     <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            lat_port  <= grant_ldr;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= grant_ldr;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          c_ready <= (lat_port == PORT_CPU);
          l_ready <= (lat_port == PORT_LDR);
          c_err   <= (lat_port == PORT_CPU) && lat_err;
          l_err   <= (lat_port == PORT_LDR) && lat_err;
          if (lat_port == PORT_CPU) c_rdata <= rd_val;
          else                      l_rdata <= rd_val;
          state   <= RESP;
        end
        RESP: begin
          c_ready <= 1'b0;
          l_ready <= 1'b0;
          c_err   <= 1'b0;
          l_err   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address/data hold the last latched request; enables only fire in ACCESS.
  assign ram_address    = lat_addr;
  assign ram_data_write = lat_wdata;
  assign ram_write_en   = (state == ACCESS) && lat_we && !lat_err;
  assign ram_read_en    = (state == ACCESS) && !lat_we && !lat_err;
  assign state_dbg      = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: behavioural 32-word RAM, immediate-assertion checks.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_ready, c_err, l_ready, l_err;
  logic [31:0] c_rdata, l_rdata;
  logic [31:0] ram_address, ram_data_write, ram_data_out;
  logic        ram_write_en, ram_read_en;
  logic [1:0]  state_dbg;

  logic [31:0] mem [32];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int n_checks = 0;
  int n_pass   = 0;

  ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata), .c_err(c_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ready(l_ready), .l_rdata(l_rdata), .l_err(l_err),
    .ram_address(ram_address), .ram_data_write(ram_data_write),
    .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_data_out(ram_data_out), .state_dbg(state_dbg)
  );

  // Clock / reset and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_out = (ram_address < 32'd128) ? mem[ram_address[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (ram_write_en) begin
      mem[ram_address[6:2]] <= ram_data_write;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: one transaction on a port, checked against hand-computed values.
  task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input string tag);
    int lat;
    int wec;
    logic got;
    @(negedge clk);
    if (port) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    lat = 0; wec = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ram_write_en) wec++;
      if (port ? l_ready : c_ready) got = 1'b1;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_rdata"}, port ? l_rdata : c_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, port ? l_err : c_err}, {31'b0, exp_err});
    check({tag, "_other_ready"}, {31'b0, port ? c_ready : l_ready}, 32'd0);
    check({tag, "_we_cycles"}, wec, (we && !exp_err) ? 1 : 0);
    if (port) l_req = 1'b0;
    else      c_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("rst_c_ready", {31'b0, c_ready}, 32'd0);
    check("rst_l_ready", {31'b0, l_ready}, 32'd0);
    check("rst_errs", {30'b0, c_err, l_err}, 32'd0);
    check("rst_c_rdata", c_rdata, 32'd0);
    check("rst_l_rdata", l_rdata, 32'd0);
    check("rst_ram_addr", ram_address, 32'd0);
    check("rst_ram_wdata", ram_data_write, 32'd0);
    check("rst_ram_en", {30'b0, ram_write_en, ram_read_en}, 32'd0);

    // CPU write, step by step
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h08; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("wr_state_access", {30'b0, state_dbg}, 32'd1);
    check("wr_we", {31'b0, ram_write_en}, 32'd1);
    check("wr_re", {31'b0, ram_read_en}, 32'd0);
    check("wr_addr", ram_address, 32'h08);
    check("wr_data", ram_data_write, 32'hDEADBEEF);
    check("wr_ready_early", {31'b0, c_ready}, 32'd0);
    @(negedge clk);
    check("wr_ready", {31'b0, c_ready}, 32'd1);
    check("wr_err", {31'b0, c_err}, 32'd0);
    check("wr_rdata_zero", c_rdata, 32'd0);
    check("wr_we_off", {31'b0, ram_write_en}, 32'd0);
    check("wr_addr_hold", ram_address, 32'h08);
    c_req = 1'b0;
    @(negedge clk);
    check("wr_ready_drop", {31'b0, c_ready}, 32'd0);
    check("wr_state_idle", {30'b0, state_dbg}, 32'd0);

    // Read-back and loader path
    txn(1'b0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, "cpu_rd08");
    txn(1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0, "ldr_wr10");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, "cpu_rd10");
    txn(1'b0, 1'b0, 32'h7C, 32'h0, 32'hA000_001F, 1'b0, "cpu_rd_top");

    // Rejected accesses
    txn(1'b1, 1'b1, 32'h06, 32'hFFFF_FFFF, 32'h0, 1'b1, "ldr_misalign");
    txn(1'b1, 1'b1, 32'h80, 32'hFFFF_FFFF, 32'h0, 1'b1, "ldr_range");
    txn(1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1, "cpu_rd_range");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, "cpu_rd_after_err");

    // Simultaneous requests after reset: CPU wins the first tie
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h04;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h0C;
    repeat (2) @(negedge clk);
    check("tie_c_ready", {31'b0, c_ready}, 32'd1);
    check("tie_l_ready", {31'b0, l_ready}, 32'd0);
    check("tie_c_rdata", c_rdata, 32'hA000_0001);
    c_req = 1'b0;
    repeat (3) @(negedge clk);
    check("tie2_l_ready", {31'b0, l_ready}, 32'd1);
    check("tie2_c_ready", {31'b0, c_ready}, 32'd0);
    check("tie2_l_rdata", l_rdata, 32'hA000_0003);

    // Both held: grant sequence
    c_req = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
`else
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
`endif
    got_q = {};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (c_ready && l_ready) got_q.push_back(32'd9);
      else if (c_ready) got_q.push_back(32'd0);
      else if (l_ready) got_q.push_back(32'd1);
    end
    c_req = 1'b0; l_req = 1'b0;
    check("alt_grants", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("alt_grant_%0d", i), (i < got_q.size()) ? got_q[i] : 32'hX, exp_q[i]);
    end

    // Reset during ACCESS
    @(negedge clk);
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h14; c_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("ra_we_on", {31'b0, ram_write_en}, 32'd1);
    reset = 1'b1; c_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("ra_we_off", {31'b0, ram_write_en}, 32'd0);
    check("ra_state", {30'b0, state_dbg}, 32'd0);
    check("ra_ready_off", {31'b0, c_ready}, 32'd0);
    got_q = {};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (c_ready) got_q.push_back(32'(i));
    end
    check("ra_no_ready", got_q.size(), 0);

    // Held CPU read: ready every 3 cycles
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h08;
    exp_q = '{32'd2, 32'd5, 32'd8};
    got_q = {};
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (c_ready) begin
        got_q.push_back(32'(i));
        check($sformatf("held_rdata_%0d", i), c_rdata, 32'hA000_0002);
      end
    end
    c_req = 1'b0;
    check("held_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("held_pos_%0d", i), (i < got_q.size()) ? got_q[i] : 32'hX, exp_q[i]);
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
